// File: rtl/cache_ctrl_pkg.sv
// Shared types for the set-associative cache controller: mux selects, FSM states, way decode.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package cache_ctrl_pkg;

   // Address mux in the datapath: CPU address, stored tag (write-back), or flush walk index.
   typedef enum logic [1:0] {
      addr_from_cpu   = 2'd0,
      addr_from_array = 2'd1,
      addr_flush      = 2'd2
   } addrmux_sel_t;

   // Data-array write source: refill line from memory or CPU store data.
   typedef enum logic {
      data_from_memory = 1'b0,
      data_from_cpu    = 1'b1
   } datamux_sel_t;

   // Byte-enable source: full line on refill, CPU byte mask on stores.
   typedef enum logic {
      all_enable  = 1'b0,
      spec_by_cpu = 1'b1
   } benmux_sel_t;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      HIT_CHECK   = 3'd1,
      WRITE_BACK  = 3'd2,
      READ_MEM    = 3'd3,
      UPDATE      = 3'd4,
      FLUSH_CHECK = 3'd5,
      FLUSH_WB    = 3'd6,
      FLUSH_NEXT  = 3'd7
   } state_t;

   // Widest way vector the decode helper accepts; callers zero-extend into it.
   localparam int MAX_WAYS = 32;
   localparam int IDX_W    = 5;

   // One-hot to binary index. OR-reduction form: correct for any one-hot input,
   // and a zero input yields 0 (callers only use the result when a bit is set).
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_WAYS-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_WAYS; i++) begin
         if (vec[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
// Latency: count visible the cycle after the inc pulse.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: +1 on inc unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache with flush walk.
// Latency: hit 2 cycles, clean miss 3 cycles + line-read wait, dirty miss adds line-write wait.
// Backpressure: CPU request held until cpu_resp; adaptor transfers held until ca_resp.
module assoc_cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter  int WAYS  = 4,   // power of two, 2..MAX_WAYS
   parameter  int SETS  = 8,   // power of two, >= 2
   parameter  int CNT_W = 16,
   localparam int WAY_W = $clog2(WAYS),
   localparam int SET_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_read,
   input  logic             cpu_write,
   output logic             cpu_resp,
   input  logic             flush_req,
   output logic             flush_done,
   output logic             flush_active,
   output logic             ca_read,
   output logic             ca_write,
   input  logic             ca_resp,
   input  logic [WAYS-1:0]  hit_vec,
   input  logic [WAYS-1:0]  valid_vec,
   input  logic [WAYS-1:0]  dirty_vec,
   input  logic [WAY_W-1:0] plru_victim,
   output logic [WAY_W-1:0] way_sel,
   output logic [SET_W-1:0] set_idx,
   output addrmux_sel_t     addr_sel,
   output datamux_sel_t     data_sel,
   output benmux_sel_t      ben_sel,
   output logic             data_write,
   output logic             tag_write,
   output logic             valid_write,
   output logic             lru_write,
   output logic             dirty_write,
   output logic             dirty_val,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   state_t           state_q, state_d;
   logic [WAY_W-1:0] victim_q, victim_d;
   logic [WAY_W-1:0] fway_q, fway_d;
   logic [SET_W-1:0] fset_q, fset_d;

   logic             cpu_req;
   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             inv_found;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] miss_victim;
   logic             miss_victim_dirty;
   logic             flush_way_dirty;
   logic             last_way;
   logic             last_set;

   assign cpu_req = cpu_read | cpu_write;
   assign hit     = |hit_vec;
   assign hit_way = WAY_W'(onehot_to_idx(MAX_WAYS'(hit_vec)));

   // Victim priority encoder: lowest-index invalid way, so empty slots fill before anything is evicted.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (!valid_vec[i] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(i);
         end
      end
   end

   // Only a valid, dirty victim needs writing back; an invalid pick is always clean by construction.
   assign miss_victim       = inv_found ? inv_way : plru_victim;
   assign miss_victim_dirty = valid_vec[miss_victim] & dirty_vec[miss_victim];
   assign flush_way_dirty   = valid_vec[fway_q] & dirty_vec[fway_q];

   assign last_way = (fway_q == WAY_W'(WAYS - 1));
   assign last_set = (fset_q == SET_W'(SETS - 1));

   assign set_idx      = fset_q;
   assign flush_active = (state_q == FLUSH_CHECK) || (state_q == FLUSH_WB) ||
                         (state_q == FLUSH_NEXT);

   // Next-state and output decode; every output starts from its idle default.
   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      fway_d      = fway_q;
      fset_d      = fset_q;
      cpu_resp    = 1'b0;
      flush_done  = 1'b0;
      ca_read     = 1'b0;
      ca_write    = 1'b0;
      addr_sel    = addr_from_cpu;
      data_sel    = data_from_memory;
      ben_sel     = all_enable;
      way_sel     = victim_q;
      data_write  = 1'b0;
      tag_write   = 1'b0;
      valid_write = 1'b0;
      lru_write   = 1'b0;
      dirty_write = 1'b0;
      dirty_val   = 1'b0;

      case (state_q)
         IDLE: begin
            // CPU traffic takes priority; a pending flush waits for the next idle cycle.
            if (cpu_req) begin
               state_d = HIT_CHECK;
            end else if (flush_req) begin
               state_d = FLUSH_CHECK;
               fway_d  = '0;
               fset_d  = '0;
            end
         end

         HIT_CHECK: begin
            if (hit) begin
               way_sel   = hit_way;
               cpu_resp  = 1'b1;
               lru_write = 1'b1;
               if (cpu_write) begin
                  data_write  = 1'b1;
                  data_sel    = data_from_cpu;
                  ben_sel     = spec_by_cpu;
                  dirty_write = 1'b1;
                  dirty_val   = 1'b1;
               end
               state_d = IDLE;
            end else begin
               victim_d = miss_victim;
               state_d  = miss_victim_dirty ? WRITE_BACK : READ_MEM;
            end
         end

         WRITE_BACK: begin
            ca_write = 1'b1;
            addr_sel = addr_from_array;
            if (ca_resp) state_d = READ_MEM;
         end

         READ_MEM: begin
            ca_read = 1'b1;
            // Refill lands in the same cycle the adaptor completes; the line is clean until UPDATE.
            if (ca_resp) begin
               data_write  = 1'b1;
               dirty_write = 1'b1;
               dirty_val   = 1'b0;
               state_d     = UPDATE;
            end
         end

         UPDATE: begin
            tag_write   = 1'b1;
            valid_write = 1'b1;
            lru_write   = 1'b1;
            cpu_resp    = 1'b1;
            // A store miss merges the CPU bytes over the freshly refilled line.
            if (cpu_write) begin
               data_write  = 1'b1;
               data_sel    = data_from_cpu;
               ben_sel     = spec_by_cpu;
               dirty_write = 1'b1;
               dirty_val   = 1'b1;
            end
            state_d = IDLE;
         end

         FLUSH_CHECK: begin
            addr_sel = addr_flush;
            way_sel  = fway_q;
            state_d  = flush_way_dirty ? FLUSH_WB : FLUSH_NEXT;
         end

         FLUSH_WB: begin
            ca_write = 1'b1;
            addr_sel = addr_flush;
            way_sel  = fway_q;
            // Line stays valid; only the dirty bit is cleared once memory holds the data.
            if (ca_resp) begin
               dirty_write = 1'b1;
               dirty_val   = 1'b0;
               state_d     = FLUSH_NEXT;
            end
         end

         FLUSH_NEXT: begin
            fway_d = fway_q + WAY_W'(1);
            if (last_way) fset_d = fset_q + SET_W'(1);
            if (last_way && last_set) begin
               flush_done = 1'b1;
               state_d    = IDLE;
            end else begin
               state_d = FLUSH_CHECK;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State, victim and flush-walk registers; reset drops any in-flight adaptor transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         victim_q <= '0;
         fway_q   <= '0;
         fset_q   <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         fway_q   <= fway_d;
         fset_q   <= fset_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ((state_q == HIT_CHECK) && hit),
      .cnt   (hit_count)
   );

   sat_counter #(.W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   ((state_q == HIT_CHECK) && !hit),
      .cnt   (miss_count)
   );

   // A tag can live in at most one way of a set; more than one hit means corrupt tag arrays.
   hit_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == HIT_CHECK) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Randomised scoreboard bench: a cache model predicts each transaction and flush walk.
// Latency: checks exact cpu_resp / flush_done cycles against the predicted durations.
// Backpressure: a modelled cacheline adaptor answers after a per-transaction random delay.
`timescale 1ns/1ps
module tb_assoc_cache_ctrl;
   import cache_ctrl_pkg::*;

   localparam int WAYS  = 4;
   localparam int SETS  = 2;
   localparam int CNT_W = 2;
   localparam int WAY_W = 2;
   localparam int SET_W = 1;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             cpu_read, cpu_write, cpu_resp;
   logic             flush_req, flush_done, flush_active;
   logic             ca_read, ca_write, ca_resp;
   logic [WAYS-1:0]  hit_vec, valid_vec, dirty_vec;
   logic [WAY_W-1:0] plru_victim, way_sel;
   logic [SET_W-1:0] set_idx;
   addrmux_sel_t     addr_sel;
   datamux_sel_t     data_sel;
   benmux_sel_t      ben_sel;
   logic             data_write, tag_write, valid_write, lru_write, dirty_write, dirty_val;
   logic [CNT_W-1:0] hit_count, miss_count;

   assoc_cache_ctrl #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_resp(cpu_resp),
      .flush_req(flush_req), .flush_done(flush_done), .flush_active(flush_active),
      .ca_read(ca_read), .ca_write(ca_write), .ca_resp(ca_resp),
      .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
      .plru_victim(plru_victim), .way_sel(way_sel), .set_idx(set_idx),
      .addr_sel(addr_sel), .data_sel(data_sel), .ben_sel(ben_sel),
      .data_write(data_write), .tag_write(tag_write), .valid_write(valid_write),
      .lru_write(lru_write), .dirty_write(dirty_write), .dirty_val(dirty_val),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath arrays written only by DUT strobes, and the reference cache written by the model.
   bit dp_valid [SETS][WAYS];
   bit dp_dirty [SETS][WAYS];
   int dp_tag   [SETS][WAYS];
   bit rf_valid [SETS][WAYS];
   bit rf_dirty [SETS][WAYS];
   int rf_tag   [SETS][WAYS];

   int cur_set = 0, cur_tag = 0, rd_delay = 0, wb_delay = 0;
   int n_hits = 0, n_misses = 0;

   typedef struct {
      bit is_write;
      bit is_hit;
      bit wb;
      int way;
      int start;
      int lat;
      int hits;
      int misses;
   } cpu_exp_t;

   cpu_exp_t cpuq[$];
   int       wbq[$];
   int       doneq[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Datapath/adaptor model: present the indexed set's status and answer transfers after a delay.
   initial begin : env
      int cnt, last_op, op, s;
      bit resp_prev;
      cnt = 0; last_op = 0; resp_prev = 0;
      hit_vec = '0; valid_vec = '0; dirty_vec = '0; ca_resp = 1'b0;
      forever begin
         @(posedge clk); #2;
         s = flush_active ? int'(set_idx) : cur_set;
         for (int w = 0; w < WAYS; w++) begin
            valid_vec[w] = dp_valid[s][w];
            dirty_vec[w] = dp_dirty[s][w];
            hit_vec[w]   = dp_valid[s][w] && (dp_tag[s][w] == cur_tag);
         end
         op = ca_write ? 2 : (ca_read ? 1 : 0);
         if (op != last_op || resp_prev) cnt = 0;
         ca_resp = 1'b0;
         if (op != 0) begin
            ca_resp = (cnt == ((op == 2) ? wb_delay : rd_delay));
            cnt++;
         end
         resp_prev = ca_resp;
         last_op   = op;
      end
   end

   // Array writes take effect at the clock edge that ends the strobe cycle.
   initial begin : arrays
      int s, w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            s = flush_active ? int'(set_idx) : cur_set;
            w = int'(way_sel);
            if (valid_write) dp_valid[s][w] = 1'b1;
            if (tag_write)   dp_tag[s][w]   = cur_tag;
            if (dirty_write) dp_dirty[s][w] = dirty_val;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT completes a transfer, response or flush.
   initial begin : monitor
      int n_wb, n_rd, x, d;
      bit cnt_chk, fdone_chk;
      cpu_exp_t h, last;
      n_wb = 0; n_rd = 0; cnt_chk = 0; fdone_chk = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            n_wb = 0; n_rd = 0; cnt_chk = 0; fdone_chk = 0;
         end else begin
            if (cnt_chk) begin
               check("hit_count", hit_count, last.hits);
               check("miss_count", miss_count, last.misses);
               cnt_chk = 0;
            end
            if (fdone_chk) begin
               check("flush_active_after_done", flush_active, 0);
               fdone_chk = 0;
            end
            if (flush_active) begin
               if (ca_write && ca_resp) begin
                  if (wbq.size() == 0) begin
                     check("flush_wb_unexpected", 1, 0);
                  end else begin
                     x = wbq.pop_front();
                     check("flush_wb_set", set_idx, x / WAYS);
                     check("flush_wb_way", way_sel, x % WAYS);
                     check("flush_wb_addr_sel", addr_sel, addr_flush);
                     check("flush_wb_dirty_clear", {dirty_write, dirty_val}, 2'b10);
                  end
               end
               if (flush_done) begin
                  check("flush_wb_count", wbq.size(), 0);
                  wbq.delete();
                  if (doneq.size() == 0) begin
                     check("flush_done_unexpected", 1, 0);
                  end else begin
                     d = doneq.pop_front();
                     check("flush_done_cycle", cyc, d);
                  end
                  fdone_chk = 1;
               end
            end else begin
               if (ca_write && ca_resp) begin
                  n_wb++;
                  if (cpuq.size() != 0) begin
                     check("wb_way", way_sel, cpuq[0].way);
                     check("wb_addr_sel", addr_sel, addr_from_array);
                  end
               end
               if (ca_read && ca_resp) begin
                  n_rd++;
                  if (cpuq.size() != 0) check("refill_way", way_sel, cpuq[0].way);
                  check("refill_strobes", {data_write, dirty_write, dirty_val}, 3'b110);
               end
               if (cpu_resp) begin
                  if (cpuq.size() == 0) begin
                     check("cpu_resp_unexpected", 1, 0);
                  end else begin
                     h = cpuq.pop_front();
                     check("resp_way", way_sel, h.way);
                     check("resp_latency", cyc - h.start, h.lat);
                     check("resp_wb_count", n_wb, h.wb);
                     check("resp_rd_count", n_rd, !h.is_hit);
                     check("resp_lru_write", lru_write, 1);
                     check("resp_tag_valid_write", {tag_write, valid_write}, h.is_hit ? 2'b00 : 2'b11);
                     check("resp_data_write", data_write, h.is_write);
                     check("resp_dirty", {dirty_write, dirty_val}, h.is_write ? 2'b11 : 2'b00);
                     if (h.is_write) begin
                        check("resp_data_sel", data_sel, data_from_cpu);
                        check("resp_ben_sel", ben_sel, spec_by_cpu);
                     end
                     last = h;
                     cnt_chk = 1;
                  end
                  n_wb = 0;
                  n_rd = 0;
               end
            end
         end
      end
   end

   // Reference cache: predict hit/miss, victim, write-back need and latency from the cache rules.
   task automatic cpu_issue(input bit wr, input int s, input int tg, input int plru,
                            input int start_cyc, output int lat);
      cpu_exp_t e;
      int hw, v;
      hw = -1;
      for (int w = 0; w < WAYS; w++)
         if (rf_valid[s][w] && rf_tag[s][w] == tg) hw = w;
      e.is_write = wr;
      e.start    = start_cyc;
      if (hw >= 0) begin
         e.is_hit = 1; e.wb = 0; e.way = hw; e.lat = 1;
         n_hits++;
         if (wr) rf_dirty[s][hw] = 1'b1;
      end else begin
         v = -1;
         for (int w = 0; w < WAYS; w++)
            if (!rf_valid[s][w] && v < 0) v = w;
         if (v < 0) v = plru;
         e.is_hit = 0;
         e.way    = v;
         e.wb     = rf_valid[s][v] && rf_dirty[s][v];
         e.lat    = 3 + rd_delay + (e.wb ? wb_delay + 1 : 0);
         n_misses++;
         rf_valid[s][v] = 1'b1;
         rf_tag[s][v]   = tg;
         rf_dirty[s][v] = wr;
      end
      e.hits   = (n_hits > CMAX) ? CMAX : n_hits;
      e.misses = (n_misses > CMAX) ? CMAX : n_misses;
      cpuq.push_back(e);
      cur_set     = s;
      cur_tag     = tg;
      plru_victim = WAY_W'(plru);
      cpu_read    = !wr;
      cpu_write   = wr;
      lat         = e.lat;
   endtask

   task automatic cpu_wait();
      bit seen;
      seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (cpu_resp) seen = 1;
      end
      check("cpu_resp_timeout", seen, 1);
      if (!seen) cpuq.delete();
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   // Flush walk: set-major, way-minor; 2 cycles per entry plus (write wait + 1) per dirty line.
   task automatic flush_issue(input int start_cyc);
      int tot;
      tot = 0;
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            tot += 2;
            if (rf_valid[s][w] && rf_dirty[s][w]) begin
               wbq.push_back(s * WAYS + w);
               tot += wb_delay + 1;
               rf_dirty[s][w] = 1'b0;
            end
         end
      end
      doneq.push_back(start_cyc + tot);
      flush_req = 1'b1;
   endtask

   task automatic flush_wait();
      bit seen;
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (flush_done) seen = 1;
      end
      check("flush_done_timeout", seen, 1);
      if (!seen) begin
         wbq.delete();
         doneq.delete();
      end
      flush_req = 1'b0;
   endtask

   initial begin : stim
      int lat, r, s, tg;
      bit seen;
      cpu_read = 1'b0; cpu_write = 1'b0; flush_req = 1'b0; plru_victim = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cpu_resp", cpu_resp, 0);
      check("rst_ca", {ca_read, ca_write}, 0);
      check("rst_flush", {flush_active, flush_done}, 0);
      check("rst_strobes", {data_write, tag_write, valid_write, lru_write, dirty_write, dirty_val}, 0);
      check("rst_addr_sel", addr_sel, addr_from_cpu);
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         rd_delay = $urandom_range(0, 3);
         wb_delay = $urandom_range(0, 3);
         r  = $urandom_range(0, 11);
         s  = $urandom_range(0, SETS - 1);
         tg = $urandom_range(0, 5);
         if (r == 0) begin
            flush_issue(cyc);
            flush_wait();
         end else if (r == 1) begin
            // Simultaneous request and flush: the CPU access must complete first.
            cpu_issue($urandom_range(0, 1), s, tg, $urandom_range(0, WAYS - 1), cyc, lat);
            flush_issue(cyc + lat + 1);
            cpu_wait();
            flush_wait();
         end else begin
            cpu_issue($urandom_range(0, 1), s, tg, $urandom_range(0, WAYS - 1), cyc, lat);
            cpu_wait();
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      @(negedge clk);
      for (int a = 0; a < SETS; a++) begin
         for (int w = 0; w < WAYS; w++) begin
            check("final_valid", dp_valid[a][w], rf_valid[a][w]);
            if (rf_valid[a][w]) begin
               check("final_tag", dp_tag[a][w], rf_tag[a][w]);
               check("final_dirty", dp_dirty[a][w], rf_dirty[a][w]);
            end
         end
      end

      // Asynchronous reset while a line read is outstanding.
      @(posedge clk); #1;
      rd_delay = 10;
      wb_delay = 0;
      cpu_issue(1'b0, 0, 99, 0, cyc, lat);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (ca_read) seen = 1;
      end
      check("rst_mid_ca_read_seen", seen, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_ca_read_drop", ca_read, 0);
      check("rst_mid_hit_count", hit_count, 0);
      check("rst_mid_miss_count", miss_count, 0);
      cpu_read = 1'b0;
      cpu_write = 1'b0;
      cpuq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", {ca_read, ca_write, cpu_resp, flush_active}, 0);
      check("post_rst_counts", {hit_count, miss_count}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
